// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-back/write-allocate data cache controller
// Owns tag/valid/dirty state; drives the word-per-line data memory and a req/ack main-memory port.
module cache_controller #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 2,
    parameter int IDX_W    = 5,
    parameter int DATA_W   = 32
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              data_we,
    output logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] data_block_in,
    input  logic [DATA_W-1:0] data_block_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int TAG_W    = ADDR_W - IDX_W - OFFSET_W;
    localparam int IDX_SIZE = 2 ** IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_REFILL
    } state_t;

    state_t                       state_q, state_d;
    logic [ADDR_W-OFFSET_W-1:0]   addr_q, addr_d;
    logic                         we_q, we_d;
    logic [DATA_W-1:0]            wdata_q, wdata_d;
    logic [3:0]                   wstrb_q, wstrb_d;
    logic [IDX_SIZE-1:0]          valid_q, valid_d;
    logic [IDX_SIZE-1:0]          dirty_q, dirty_d;
    logic [TAG_W-1:0]             tag_q [IDX_SIZE];
    logic [TAG_W-1:0]             tag_d [IDX_SIZE];

    logic [IDX_W-1:0]  cur_idx;
    logic [TAG_W-1:0]  cur_tag;
    logic [TAG_W-1:0]  line_tag;
    logic              hit;
    logic [DATA_W-1:0] merged;
    logic              unused_offset;

    // Byte offset never participates in lookup; the line is one word wide.
    assign unused_offset = ^cpu_addr[OFFSET_W-1:0];

    assign cur_idx  = addr_q[IDX_W-1:0];
    assign cur_tag  = addr_q[ADDR_W-OFFSET_W-1 -: TAG_W];
    assign line_tag = tag_q[cur_idx];
    assign hit      = valid_q[cur_idx] && (line_tag == cur_tag);

    always_comb begin
        merged = data_block_out;
        for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) begin
                merged[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        tag_d         = tag_q;
        cpu_rdata     = '0;
        cpu_ready     = 1'b0;
        data_we       = 1'b0;
        data_block_in = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        // The data memory is read asynchronously, so IDLE looks ahead at the incoming address.
        idx = (state_q == S_IDLE) ? cpu_addr[OFFSET_W +: IDX_W] : cur_idx;

        unique case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr[ADDR_W-1:OFFSET_W];
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    wstrb_d = cpu_wstrb;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    cpu_ready = 1'b1;
                    if (we_q) begin
                        data_we          = 1'b1;
                        data_block_in    = merged;
                        dirty_d[cur_idx] = 1'b1;
                    end else begin
                        cpu_rdata = data_block_out;
                    end
                    state_d = S_IDLE;
                end else if (valid_q[cur_idx] && dirty_q[cur_idx]) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_REFILL;
                end
            end
            S_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {line_tag, cur_idx, {OFFSET_W{1'b0}}};
                mem_wdata = data_block_out;
                if (mem_ack) begin
                    dirty_d[cur_idx] = 1'b0;
                    state_d          = S_REFILL;
                end
            end
            S_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {cur_tag, cur_idx, {OFFSET_W{1'b0}}};
                if (mem_ack) begin
                    data_we          = 1'b1;
                    data_block_in    = mem_rdata;
                    tag_d[cur_idx]   = cur_tag;
                    valid_d[cur_idx] = 1'b1;
                    dirty_d[cur_idx] = 1'b0;
                    // Return to COMPARE so a store merge happens on the freshly filled line.
                    state_d          = S_COMPARE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A store caught by reset must not reach the data memory.
        if (iRST) begin
            cpu_ready = 1'b0;
            data_we   = 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge iCLK) begin
        tag_q <= tag_d;
    end
endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - self-checking bench for cache_controller
// Flat-memory reference model plus cache-state bookkeeping predicts hits, write-backs and data.
module tb_cache_controller;
    logic        clk = 1'b0;
    logic        iRST;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ready, data_we;
    logic [4:0]  idx;
    logic [31:0] data_block_in, data_block_out;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [31:0] rdata;
        int          lat;
        bit          timeout;
        int          nmem;
        logic        dwe;
        logic [31:0] dbi;
    } obs_t;

    typedef struct packed {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } memtx_t;

    typedef struct packed {
        bit          hit;
        bit          wb;
        logic [31:0] wb_addr;
        logic [31:0] wb_data;
        logic [31:0] rf_addr;
        logic [31:0] rdata;
    } exp_t;

    cache_controller dut (
        .iCLK(clk), .iRST(iRST),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .data_we(data_we), .idx(idx), .data_block_in(data_block_in), .data_block_out(data_block_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Cache data memory: asynchronous read, synchronous write.
    logic [31:0] dmem [32];
    assign data_block_out = dmem[idx];
    always @(posedge clk) if (data_we) dmem[idx] <= data_block_in;

    logic [31:0] mm [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic        rv [32];
    logic        rdy [32];
    logic [24:0] rt [32];
    memtx_t      mlog [$];
    int          mem_delay = 0;
    int          wcnt = 0;

    function automatic logic [31:0] dflt(input logic [31:0] wa);
        return {wa[15:0] ^ 16'hBEEF, wa[15:0]};
    endfunction

    function automatic logic [31:0] mm_rd(input logic [31:0] wa);
        if (mm.exists(wa)) return mm[wa];
        return dflt(wa);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return dflt(wa);
    endfunction

    function automatic void ref_reset();
        for (int i = 0; i < 32; i++) begin
            rv[i]  = 1'b0;
            rdy[i] = 1'b0;
        end
        ref_mem = mm;
    endfunction

    function automatic exp_t model_access(input bit we, input logic [31:0] a,
                                          input logic [31:0] wd, input logic [3:0] ws);
        exp_t        e;
        logic [31:0] wa;
        logic [31:0] cur;
        logic [4:0]  i;
        logic [24:0] t;
        wa = {a[31:2], 2'b00};
        i  = a[6:2];
        t  = a[31:7];
        e  = '0;
        e.hit     = rv[i] && (rt[i] == t);
        e.rf_addr = wa;
        if (!e.hit) begin
            if (rv[i] && rdy[i]) begin
                e.wb      = 1'b1;
                e.wb_addr = {rt[i], i, 2'b00};
                e.wb_data = ref_rd(e.wb_addr);
            end
            rv[i]  = 1'b1;
            rt[i]  = t;
            rdy[i] = 1'b0;
        end
        cur = ref_rd(wa);
        if (we) begin
            for (int b = 0; b < 4; b++) if (ws[b]) cur[8*b +: 8] = wd[8*b +: 8];
            ref_mem[wa] = cur;
            rdy[i] = 1'b1;
        end
        e.rdata = cur;
        return e;
    endfunction

    // Main-memory responder: acks after mem_delay cycles, one-cycle ack pulse.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (mem_req && !iRST) begin
                if (wcnt >= mem_delay) begin
                    mlog.push_back({mem_we, mem_addr, mem_wdata});
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mm[mem_addr] = mem_wdata;
                        mem_rdata    = $urandom;
                    end else begin
                        mem_rdata = mm_rd(mem_addr);
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic cpu_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, output obs_t o);
        bit done;
        mlog.delete();
        o = '0;
        o.timeout = 1'b1;
        done = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_wstrb = ws;
        for (int n = 1; n <= 200 && !done; n++) begin
            @(negedge clk);
            if (cpu_ready) begin
                o.lat = n; o.rdata = cpu_rdata; o.dwe = data_we; o.dbi = data_block_in;
                o.timeout = 1'b0;
                done = 1'b1;
            end
        end
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_wstrb = '0;
        o.nmem = mlog.size();
    endtask

    task automatic test_reset;
        iRST = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({cpu_ready, data_we, mem_req, mem_we} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want 0000", {cpu_ready, data_we, mem_req, mem_we});
        end
        iRST = 1'b0;
        ref_reset();
        @(negedge clk);
        tests_run++;
        if ({cpu_ready, data_we, mem_req, mem_we} !== 4'b0) begin
            tests_failed++;
            $display("FAIL idle_outputs: got %b want 0000", {cpu_ready, data_we, mem_req, mem_we});
        end
    endtask

    task automatic test_clean_miss;
        obs_t o;
        exp_t e;
        mm[32'h40] = 32'hDEADBEEF;
        ref_mem[32'h40] = 32'hDEADBEEF;
        mem_delay = 0;
        e = model_access(1'b0, 32'h40, '0, '0);
        cpu_access(1'b0, 32'h40, '0, '0, o);
        tests_run++;
        if (o.timeout || o.rdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL s1_miss_rdata: got %h (timeout %0d) want deadbeef", o.rdata, o.timeout);
        end
        tests_run++;
        if (o.nmem !== 1 || mlog[0].we !== 1'b0 || mlog[0].addr !== 32'h40) begin
            tests_failed++;
            $display("FAIL s1_refill_req: got n=%0d addr=%h want n=1 rd 00000040", o.nmem, o.nmem > 0 ? mlog[0].addr : 32'h0);
        end
        tests_run++;
        if (o.lat !== 3) begin
            tests_failed++;
            $display("FAIL s1_miss_latency: got %0d want 3", o.lat);
        end
        e = model_access(1'b0, 32'h43, '0, '0);
        cpu_access(1'b0, 32'h43, '0, '0, o);
        tests_run++;
        if (o.lat !== 1 || o.nmem !== 0 || o.rdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL s1_hit: got lat=%0d n=%0d rdata=%h want lat=1 n=0 rdata=deadbeef", o.lat, o.nmem, o.rdata);
        end
    endtask

    task automatic test_store_hit;
        obs_t o;
        exp_t e;
        e = model_access(1'b1, 32'h40, 32'h11223344, 4'b0011);
        cpu_access(1'b1, 32'h40, 32'h11223344, 4'b0011, o);
        tests_run++;
        if (o.lat !== 1 || o.nmem !== 0 || o.dwe !== 1'b1 || o.dbi !== 32'hDEAD3344) begin
            tests_failed++;
            $display("FAIL s2_store_hit: got lat=%0d n=%0d we=%b dbi=%h want lat=1 n=0 we=1 dbi=dead3344", o.lat, o.nmem, o.dwe, o.dbi);
        end
    endtask

    task automatic test_dirty_evict;
        obs_t o;
        exp_t e;
        mm[32'hC40] = 32'hCAFE0C40;
        ref_mem[32'hC40] = 32'hCAFE0C40;
        e = model_access(1'b0, 32'hC40, '0, '0);
        cpu_access(1'b0, 32'hC40, '0, '0, o);
        tests_run++;
        if (o.nmem !== 2) begin
            tests_failed++;
            $display("FAIL s3_txn_count: got %0d want 2", o.nmem);
        end else begin
            tests_run++;
            if (mlog[0].we !== 1'b1 || mlog[0].addr !== 32'h40 || mlog[0].wdata !== 32'hDEAD3344) begin
                tests_failed++;
                $display("FAIL s3_writeback: got we=%b addr=%h data=%h want 1 00000040 dead3344", mlog[0].we, mlog[0].addr, mlog[0].wdata);
            end
            tests_run++;
            if (mlog[1].we !== 1'b0 || mlog[1].addr !== 32'hC40) begin
                tests_failed++;
                $display("FAIL s3_refill: got we=%b addr=%h want 0 00000c40", mlog[1].we, mlog[1].addr);
            end
        end
        tests_run++;
        if (o.rdata !== 32'hCAFE0C40) begin
            tests_failed++;
            $display("FAIL s3_rdata: got %h want cafe0c40", o.rdata);
        end
        e = model_access(1'b0, 32'h40, '0, '0);
        cpu_access(1'b0, 32'h40, '0, '0, o);
        tests_run++;
        if (o.nmem !== 1 || o.rdata !== 32'hDEAD3344) begin
            tests_failed++;
            $display("FAIL s3_clean_evict: got n=%0d rdata=%h want n=1 rdata=dead3344", o.nmem, o.rdata);
        end
    endtask

    task automatic test_store_miss;
        obs_t o;
        exp_t e;
        mm[32'h80] = 32'h0;
        ref_mem[32'h80] = 32'h0;
        e = model_access(1'b1, 32'h80, 32'hA5A5A5A5, 4'hF);
        cpu_access(1'b1, 32'h80, 32'hA5A5A5A5, 4'hF, o);
        tests_run++;
        if (o.timeout || o.nmem !== 1 || o.dwe !== 1'b1 || o.dbi !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("FAIL s4_store_miss: got n=%0d we=%b dbi=%h want n=1 we=1 dbi=a5a5a5a5", o.nmem, o.dwe, o.dbi);
        end
        e = model_access(1'b0, 32'h1080, '0, '0);
        cpu_access(1'b0, 32'h1080, '0, '0, o);
        tests_run++;
        if (o.nmem !== 2 || mlog[0].we !== 1'b1 || mlog[0].addr !== 32'h80 || mlog[0].wdata !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("FAIL s4_dirty_line: got n=%0d first=%h/%h want 2 wb 00000080/a5a5a5a5", o.nmem, o.nmem > 0 ? mlog[0].addr : 32'h0, o.nmem > 0 ? mlog[0].wdata : 32'h0);
        end
    endtask

    task automatic test_reset_mid;
        obs_t o;
        exp_t e;
        bit   seen;
        seen = 1'b0;
        mem_delay = 10;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3F0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (mem_req && !mem_we) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL s5_refill_seen: got 0 want 1");
        end
        iRST = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({mem_req, cpu_ready, data_we} !== 3'b000) begin
            tests_failed++;
            $display("FAIL s5_reset_drop: got %b want 000", {mem_req, cpu_ready, data_we});
        end
        iRST = 1'b0;
        ref_reset();
        mem_delay = 0;
        e = model_access(1'b0, 32'h3F0, '0, '0);
        cpu_access(1'b0, 32'h3F0, '0, '0, o);
        tests_run++;
        if (o.nmem !== 1 || mlog[0].addr !== 32'h3F0 || o.rdata !== e.rdata) begin
            tests_failed++;
            $display("FAIL s5_remiss: got n=%0d rdata=%h want n=1 rdata=%h", o.nmem, o.rdata, e.rdata);
        end
    endtask

    task automatic test_writeback_stall;
        obs_t o;
        exp_t e;
        bit   seen, done;
        e = model_access(1'b1, 32'h500, 32'h12345678, 4'hF);
        cpu_access(1'b1, 32'h500, 32'h12345678, 4'hF, o);
        e = model_access(1'b0, 32'h600, '0, '0);
        mem_delay = 20;
        mlog.delete();
        seen = 1'b0;
        done = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h600;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (mem_req && mem_we) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL s6_wb_seen: got 0 want 1");
        end
        for (int k = 0; k < 20; k++) begin
            tests_run++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h500 || mem_wdata !== 32'h12345678 || cpu_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL s6_stall_cycle%0d: got req=%b addr=%h data=%h rdy=%b want 1 00000500 12345678 0", k, mem_req, mem_addr, mem_wdata, cpu_ready);
            end
            @(negedge clk);
        end
        for (int n = 0; n < 100 && !done; n++) begin
            if (cpu_ready) begin
                o.rdata = cpu_rdata;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        cpu_req = 1'b0;
        tests_run++;
        if (!done || o.rdata !== e.rdata || mlog.size() !== 2) begin
            tests_failed++;
            $display("FAIL s6_complete: got done=%0d rdata=%h n=%0d want 1 %h 2", done, o.rdata, mlog.size(), e.rdata);
        end
        mem_delay = 0;
    endtask

    task automatic test_random;
        obs_t        o;
        exp_t        e;
        bit          we;
        logic [31:0] a, wd;
        logic [3:0]  ws;
        logic [4:0]  ri;
        logic [24:0] rtag;
        int          expn;
        for (int it = 0; it < 150; it++) begin
            we   = 1'($urandom_range(0, 1));
            ri   = 5'($urandom_range(0, 3) * 9);
            rtag = 25'($urandom_range(0, 3) + 64);
            a    = {rtag, ri, 2'($urandom_range(0, 3))};
            wd   = $urandom;
            ws   = 4'($urandom_range(0, 15));
            mem_delay = $urandom_range(0, 3);
            e = model_access(we, a, wd, ws);
            cpu_access(we, a, wd, ws, o);
            expn = e.hit ? 0 : (e.wb ? 2 : 1);
            tests_run++;
            if (o.timeout || o.nmem !== expn || (e.hit && o.lat !== 1) || (!e.hit && o.lat < 3)) begin
                tests_failed++;
                $display("FAIL rnd%0d_flow: got lat=%0d n=%0d to=%0d want hit=%0d n=%0d", it, o.lat, o.nmem, o.timeout, e.hit, expn);
            end else if (expn > 0) begin
                tests_run++;
                if (mlog[expn-1].we !== 1'b0 || mlog[expn-1].addr !== e.rf_addr ||
                    (e.wb && (mlog[0].we !== 1'b1 || mlog[0].addr !== e.wb_addr || mlog[0].wdata !== e.wb_data))) begin
                    tests_failed++;
                    $display("FAIL rnd%0d_memtx: got first=%h/%h want wb=%0d %h/%h refill %h", it, mlog[0].addr, mlog[0].wdata, e.wb, e.wb_addr, e.wb_data, e.rf_addr);
                end
            end
            tests_run++;
            if (we ? (o.dwe !== 1'b1 || o.dbi !== e.rdata) : (o.rdata !== e.rdata)) begin
                tests_failed++;
                $display("FAIL rnd%0d_data: got we=%b dbi=%h rdata=%h want %h (store=%0d)", it, o.dwe, o.dbi, o.rdata, e.rdata, we);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) dmem[i] = $urandom;
        test_reset();
        test_clean_miss();
        test_store_hit();
        test_dirty_evict();
        test_store_miss();
        test_reset_mid();
        test_writeback_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
